// File: rtl/rps_match_controller_if.sv
// Player-facing bundle of the rock-paper-scissors match controller.
// The master side (console/front panel) drives the player choices and start.
// The slave side (the controller) returns the latched choices, scores and match state.
interface rps_match_controller_if #(
  parameter int SCORE_W = 4
);
  logic               start;
  logic [2:0]         player1_input;
  logic               p1_valid;
  logic [2:0]         player2_input;
  logic               p2_valid;
  logic               play_with_bot;

  logic [2:0]         player1_choice;
  logic [2:0]         player2_choice;
  logic [2:0]         round_result;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [SCORE_W-1:0] round_count;
  logic [2:0]         match_winner;
  logic               busy;

  modport master (
    output start, player1_input, p1_valid, player2_input, p2_valid, play_with_bot,
    input  player1_choice, player2_choice, round_result, p1_score, p2_score,
           round_count, match_winner, busy
  );

  modport slave (
    input  start, player1_input, p1_valid, player2_input, p2_valid, play_with_bot,
    output player1_choice, player2_choice, round_result, p1_score, p2_score,
           round_count, match_winner, busy
  );
endinterface

// File: rtl/rps_match_controller.sv
// Rock-paper-scissors match controller: collects one choice per player,
// judges the round, holds the result for a reveal period and keeps score
// until one side reaches WIN_TARGET round wins.
// Optional feature macro: RPS_BOT_EN -- builds an LFSR-driven bot that can
// stand in for player 2. Without it, player 2 always comes from the bus.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// COLLECT | waiting for both players to latch a legal one-hot choice
// JUDGE   | one cycle: decide round, update scores and round count
// REVEAL  | round result held for REVEAL_CYCLES cycles
// DONE    | match over, winner and final scores held until start
module rps_match_controller #(
  parameter int         WIN_TARGET    = 3,
  parameter int         SCORE_W       = 4,
  parameter int         REVEAL_CYCLES = 4,
  parameter logic [7:0] LFSR_SEED     = 8'hCC
) (
  input logic                  Clk,
  input logic                  Rst_n,
  rps_match_controller_if.slave bus
);

  localparam logic [2:0] ROCK     = 3'b001;
  localparam logic [2:0] SCISSORS = 3'b010;
  localparam logic [2:0] PAPER    = 3'b100;
  localparam logic [2:0] RES_P1   = 3'b100;
  localparam logic [2:0] RES_P2   = 3'b001;
  localparam logic [2:0] RES_DRAW = 3'b010;

  localparam logic [SCORE_W-1:0] WIN_S       = SCORE_W'(WIN_TARGET);
  localparam logic [SCORE_W-1:0] ONE_S       = SCORE_W'(1);
  localparam logic [7:0]         REVEAL_LAST = 8'(REVEAL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    JUDGE   = 3'd2,
    REVEAL  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state;
  logic [7:0]         reveal_cnt;
  logic [2:0]         p1_choice;
  logic [2:0]         p2_choice;
  logic [2:0]         result;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [SCORE_W-1:0] round_count;
  logic [2:0]         winner;
  logic               busy;

  logic       p1_take;
  logic       p2_take;
  logic [2:0] p2_value;
  logic       p1_beats_p2;

  function automatic logic is_legal(input logic [2:0] v);
    return (v == ROCK) || (v == SCISSORS) || (v == PAPER);
  endfunction

`ifdef RPS_BOT_EN
  logic [7:0] lfsr;
  logic [2:0] bot_pick;
  logic [7:0] lfsr_mod3;

  // Free-running bot source, shifts left every cycle regardless of state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Bot choice is the current LFSR value folded into the three moves.
  always_comb begin
    lfsr_mod3 = lfsr % 8'd3;
    bot_pick  = ROCK;
    if (lfsr_mod3 == 8'd1)      bot_pick = SCISSORS;
    else if (lfsr_mod3 == 8'd2) bot_pick = PAPER;
  end
`else
  localparam logic [7:0] unused_lfsr_seed = LFSR_SEED;
  logic unused_play_with_bot;
  assign unused_play_with_bot = bus.play_with_bot;
`endif

  // Latch qualification for both sides; the bot always lands with player 1.
  always_comb begin
    p1_take  = (state == COLLECT) && (p1_choice == 3'b000) &&
               bus.p1_valid && is_legal(bus.player1_input);
    p2_take  = (state == COLLECT) && (p2_choice == 3'b000) &&
               bus.p2_valid && is_legal(bus.player2_input);
    p2_value = bus.player2_input;
`ifdef RPS_BOT_EN
    if (bus.play_with_bot) begin
      p2_take  = p1_take && (p2_choice == 3'b000);
      p2_value = bot_pick;
    end
`endif
  end

  // Round rule: each move beats the next one in the rock->scissors->paper cycle.
  always_comb begin
    p1_beats_p2 = ((p1_choice == ROCK)     && (p2_choice == SCISSORS)) ||
                  ((p1_choice == SCISSORS) && (p2_choice == PAPER))    ||
                  ((p1_choice == PAPER)    && (p2_choice == ROCK));
  end

  // Match sequencing with all outputs registered alongside the state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      reveal_cnt  <= '0;
      p1_choice   <= '0;
      p2_choice   <= '0;
      result      <= '0;
      p1_score    <= '0;
      p2_score    <= '0;
      round_count <= '0;
      winner      <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state       <= COLLECT;
            busy        <= 1'b1;
            p1_choice   <= '0;
            p2_choice   <= '0;
            result      <= '0;
            p1_score    <= '0;
            p2_score    <= '0;
            round_count <= '0;
            winner      <= '0;
          end
        end
        COLLECT: begin
          if (p1_take) p1_choice <= bus.player1_input;
          if (p2_take) p2_choice <= p2_value;
          if (((p1_choice != 3'b000) || p1_take) &&
              ((p2_choice != 3'b000) || p2_take)) begin
            state <= JUDGE;
          end
        end
        JUDGE: begin
          if (p1_choice == p2_choice) begin
            result <= RES_DRAW;
          end else if (p1_beats_p2) begin
            result   <= RES_P1;
            p1_score <= p1_score + ONE_S;
          end else begin
            result   <= RES_P2;
            p2_score <= p2_score + ONE_S;
          end
          if (round_count != {SCORE_W{1'b1}}) round_count <= round_count + ONE_S;
          reveal_cnt <= REVEAL_LAST;
          state      <= REVEAL;
        end
        REVEAL: begin
          if (reveal_cnt == 8'd0) begin
            if (p1_score == WIN_S) begin
              state  <= DONE;
              winner <= RES_P1;
              busy   <= 1'b0;
            end else if (p2_score == WIN_S) begin
              state  <= DONE;
              winner <= RES_P2;
              busy   <= 1'b0;
            end else begin
              state     <= COLLECT;
              p1_choice <= '0;
              p2_choice <= '0;
              result    <= '0;
            end
          end else begin
            reveal_cnt <= reveal_cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.player1_choice = p1_choice;
  assign bus.player2_choice = p2_choice;
  assign bus.round_result   = result;
  assign bus.p1_score       = p1_score;
  assign bus.p2_score       = p2_score;
  assign bus.round_count    = round_count;
  assign bus.match_winner   = winner;
  assign bus.busy           = busy;

endmodule

// File: tb/tb_rps_match_controller.sv
// Self-checking bench for rps_match_controller: directed rounds followed by
// randomized matches, compared against a move-index model of the game.
module tb_rps_match_controller;
  localparam int WIN_TARGET    = 3;
  localparam int SCORE_W       = 4;
  localparam int REVEAL_CYCLES = 4;
  localparam int RC_MAX        = (1 << SCORE_W) - 1;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  rps_match_controller_if #(.SCORE_W(SCORE_W)) bus ();

  rps_match_controller #(
    .WIN_TARGET   (WIN_TARGET),
    .SCORE_W      (SCORE_W),
    .REVEAL_CYCLES(REVEAL_CYCLES),
    .LFSR_SEED    (8'hCC)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus.slave)
  );

  int passed = 0;
  int total  = 0;

  // model: move index 0 rock, 1 scissors, 2 paper
  int m_p1, m_p2, m_rc, m_win;
  int illegal_v[5] = '{0, 3, 5, 6, 7};

`ifdef RPS_BOT_EN
  logic [7:0] m_lfsr;
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) m_lfsr <= 8'hCC;
    else        m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  end
`endif

  function automatic int code(input int idx);
    return 1 << idx;
  endfunction

  // 4 = P1 wins, 1 = P2 wins, 2 = draw
  function automatic int result_code(input int a, input int b);
    int d;
    d = (b - a + 3) % 3;
    if (d == 0) return 2;
    if (d == 1) return 4;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".p1_choice"}, bus.player1_choice, 0);
    chk({tag, ".p2_choice"}, bus.player2_choice, 0);
    chk({tag, ".result"},    bus.round_result, 0);
    chk({tag, ".p1_score"},  bus.p1_score, 0);
    chk({tag, ".p2_score"},  bus.p2_score, 0);
    chk({tag, ".rc"},        bus.round_count, 0);
    chk({tag, ".winner"},    bus.match_winner, 0);
    chk({tag, ".busy"},      bus.busy, 0);
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.p1_valid = 0; bus.p2_valid = 0;
    bus.player1_input = 0; bus.player2_input = 0; bus.play_with_bot = 0;
  endtask

  task automatic start_match(input string tag);
    bus.start = 1;
    tick();
    bus.start = 0;
    m_p1 = 0; m_p2 = 0; m_rc = 0; m_win = 0;
    chk({tag, ".busy"},   bus.busy, 1);
    chk({tag, ".rc"},     bus.round_count, 0);
    chk({tag, ".p1"},     bus.p1_score, 0);
    chk({tag, ".p2"},     bus.p2_score, 0);
    chk({tag, ".winner"}, bus.match_winner, 0);
    chk({tag, ".c1"},     bus.player1_choice, 0);
  endtask

  // Called in the JUDGE cycle (one cycle after the second side latched).
  task automatic finish_round(input string tag, input int a, input int b, input bit poke_start);
    int r;
    chk({tag, ".judge_c1"}, bus.player1_choice, code(a));
    chk({tag, ".judge_c2"}, bus.player2_choice, code(b));
    tick();
    r = result_code(a, b);
    if (r == 4) m_p1++;
    if (r == 1) m_p2++;
    if (m_rc < RC_MAX) m_rc++;
    chk({tag, ".result"}, bus.round_result, r);
    chk({tag, ".p1"},     bus.p1_score, m_p1);
    chk({tag, ".p2"},     bus.p2_score, m_p2);
    chk({tag, ".rc"},     bus.round_count, m_rc);
    chk({tag, ".busy"},   bus.busy, 1);
    for (int k = 0; k < REVEAL_CYCLES; k++) begin
      if (poke_start && k == 1) bus.start = 1;
      tick();
      bus.start = 0;
    end
    if (m_p1 == WIN_TARGET) m_win = 4;
    else if (m_p2 == WIN_TARGET) m_win = 1;
    chk({tag, ".after_busy"},   bus.busy, (m_win == 0) ? 1 : 0);
    chk({tag, ".after_winner"}, bus.match_winner, m_win);
    chk({tag, ".after_result"}, bus.round_result, (m_win == 0) ? 0 : r);
    chk({tag, ".after_c1"},     bus.player1_choice, (m_win == 0) ? 0 : code(a));
  endtask

  // Player 1 latches in cycle d1, player 2 in d2; noise drives the other cycles.
  task automatic play_round(input string tag, input int a, input int b,
                            input int d1, input int d2, input bit poke_start);
    int last;
    last = (d1 > d2) ? d1 : d2;
    for (int c = 0; c <= last; c++) begin
      if (c < d1) begin
        bus.p1_valid = 1'($urandom_range(0, 1));
        bus.player1_input = 3'(illegal_v[$urandom_range(0, 4)]);
      end else if (c == d1) begin
        bus.p1_valid = 1; bus.player1_input = 3'(code(a));
      end else begin
        bus.p1_valid = 1'($urandom_range(0, 1));
        bus.player1_input = 3'(code($urandom_range(0, 2)));
      end
      if (c < d2) begin
        bus.p2_valid = 1'($urandom_range(0, 1));
        bus.player2_input = 3'(illegal_v[$urandom_range(0, 4)]);
      end else if (c == d2) begin
        bus.p2_valid = 1; bus.player2_input = 3'(code(b));
      end else begin
        bus.p2_valid = 1'($urandom_range(0, 1));
        bus.player2_input = 3'(code($urandom_range(0, 2)));
      end
      tick();
      if (c < last) begin
        chk({tag, ".c1_wait"}, bus.player1_choice, (c >= d1) ? code(a) : 0);
        chk({tag, ".c2_wait"}, bus.player2_choice, (c >= d2) ? code(b) : 0);
      end
    end
    bus.p1_valid = 0; bus.p2_valid = 0;
    finish_round(tag, a, b, poke_start);
  endtask

  initial begin
    int a, b, rounds;
    clear_inputs();
    Rst_n = 0;
    #2;
    check_all_zero("reset");
    @(negedge Clk);
    Rst_n = 1;
    bus.p1_valid = 1; bus.player1_input = 3'b001;
    bus.p2_valid = 1; bus.player2_input = 3'b010;
    repeat (3) tick();
    check_all_zero("idle_hold");
    clear_inputs();

    // basic P1 win, both sides in the same cycle
    start_match("start1");
    play_round("p1_win", 0, 1, 0, 0, 0);
    // paper vs paper draw
    play_round("draw", 2, 2, 1, 0, 0);

    // illegal codes do not latch; first legal one does; later ones ignored
    bus.p1_valid = 1; bus.player1_input = 3'b011;
    tick(); chk("illegal_011", bus.player1_choice, 0);
    bus.player1_input = 3'b000;
    tick(); chk("illegal_000", bus.player1_choice, 0);
    bus.player1_input = 3'b010;
    tick(); chk("legal_latch", bus.player1_choice, 3'b010);
    bus.player1_input = 3'b100;
    tick(); chk("second_ignored", bus.player1_choice, 3'b010);
    bus.p1_valid = 0;
    bus.p2_valid = 1; bus.player2_input = 3'b001;
    tick();
    bus.p2_valid = 0;
    finish_round("rock_beats_scissors", 1, 0, 0);

    // close out this match for player 1, with start poked mid-reveal
    play_round("close_a", 1, 2, 2, 1, 1);
    play_round("close_b", 2, 0, 0, 3, 0);
    chk("done1_p1", bus.p1_score, 3);

    // fresh match, three straight P1 wins
    start_match("start2");
    play_round("m2_r1", 0, 1, 0, 0, 0);
    play_round("m2_r2", 1, 2, 0, 0, 0);
    play_round("m2_r3", 2, 0, 0, 0, 0);
    chk("m2_winner", bus.match_winner, 3'b100);
    chk("m2_busy", bus.busy, 0);

    // round counter saturation through a run of draws, then P2 takes it
    start_match("start3");
    for (int i = 0; i < RC_MAX + 2; i++) begin
      a = $urandom_range(0, 2);
      play_round("sat_draw", a, a, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end
    chk("rc_saturated", bus.round_count, RC_MAX);
    for (int i = 0; i < WIN_TARGET; i++) play_round("p2_sweep", 1, 0, 0, 1, 0);
    chk("m3_winner", bus.match_winner, 3'b001);

    // randomized matches
    for (int m = 0; m < 4; m++) begin
      start_match("rand_start");
      rounds = 0;
      while (m_win == 0 && rounds < 40) begin
`ifndef RPS_BOT_EN
        bus.play_with_bot = 1'($urandom_range(0, 1));
`endif
        play_round("rand", $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        rounds++;
      end
      chk("rand_match_ended", (m_win != 0) ? 1 : 0, 1);
    end
    bus.play_with_bot = 0;

`ifdef RPS_BOT_EN
    // bot rounds: P2 follows the LFSR in the cycle P1 latches, p2_valid ignored
    start_match("bot_start");
    for (int r = 0; r < 3 && m_win == 0; r++) begin
      int d1;
      logic [7:0] v;
      d1 = $urandom_range(0, 3);
      a = $urandom_range(0, 2);
      v = 8'h00;
      bus.play_with_bot = 1;
      for (int c = 0; c <= d1; c++) begin
        bus.p2_valid = 1; bus.player2_input = 3'(code($urandom_range(0, 2)));
        if (c < d1) begin
          bus.p1_valid = 1; bus.player1_input = 3'(illegal_v[$urandom_range(0, 4)]);
        end else begin
          bus.p1_valid = 1; bus.player1_input = 3'(code(a));
          v = m_lfsr;
        end
        tick();
        if (c < d1) chk("bot_p2_wait", bus.player2_choice, 0);
      end
      bus.p1_valid = 0; bus.p2_valid = 0;
      b = int'(v) % 3;
      finish_round("bot_round", a, b, 0);
    end
    bus.play_with_bot = 0;
`endif

    // reset in the middle of a reveal
    start_match("start_rst");
    bus.p1_valid = 1; bus.player1_input = 3'b100;
    bus.p2_valid = 1; bus.player2_input = 3'b001;
    tick();
    bus.p1_valid = 0; bus.p2_valid = 0;
    tick();
    tick();
    chk("pre_rst_result", bus.round_result, 3'b100);
    Rst_n = 0;
    #1;
    check_all_zero("mid_reveal_rst");
    #3;
    Rst_n = 1;
    repeat (6) tick();
    check_all_zero("post_rst_idle");
    start_match("restart");
    play_round("restart_round", 2, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
